// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_tx_ctrl_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Parity of a data byte; odd=1 inverts so the total count of ones is odd.
  function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                      input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Strobe/status bundle between the memory-map controller and the Tx engine.
interface uart_tx_ctrl_if;
  import uart_tx_ctrl_pkg::*;

  logic                      tx_data_en;
  logic [UART_DATA_BITS-1:0] Tx_Data_w;
  logic                      tx_send_en;
  logic                      tx_send;
  logic                      tx;
  logic                      tx_busy;
  logic                      tx_fsm_in_STOP_S;
  logic                      tx_done;

  // Controller side: issues load/send strobes, observes line and status.
  modport master (
    output tx_data_en, Tx_Data_w, tx_send_en, tx_send,
    input  tx, tx_busy, tx_fsm_in_STOP_S, tx_done
  );

  // Tx engine side.
  modport slave (
    input  tx_data_en, Tx_Data_w, tx_send_en, tx_send,
    output tx, tx_busy, tx_fsm_in_STOP_S, tx_done
  );

endinterface

// File: rtl/uart_tx_ctrl_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the last
// count. Clear has priority so every state starts a fresh bit period.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Count register with clear and wrap at the last clk of a bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt  = cnt_r;
  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit engine: start bit, 8 data bits LSB first, optional parity,
// one stop bit. The frame shifts from a private copy taken at start, so the
// holding register may be reloaded at any time.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_ctrl_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST =
    (CLKS_PER_BIT >= 2) ? CNT_W'(CLKS_PER_BIT - 2) : {CNT_W{1'b0}};
  localparam logic STOP_ONE_CLK = (CLKS_PER_BIT == 1) ? 1'b1 : 1'b0;
  localparam logic PAR_EN       = (PARITY_EN != 0) ? 1'b1 : 1'b0;
  localparam logic PAR_ODD      = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  tx_state_t                 state_r;
  tx_state_t                 state_nxt_s;
  logic [UART_DATA_BITS-1:0] hold_r;
  logic [UART_DATA_BITS-1:0] shift_r;
  logic [UART_DATA_BITS-1:0] shift_nxt_s;
  logic [2:0]                idx_r;
  logic [2:0]                idx_nxt_s;
  logic                      par_r;
  logic                      par_nxt_s;
  logic                      tx_r;
  logic                      tx_nxt_s;
  logic                      done_r;
  logic                      done_nxt_s;
  logic                      start_s;
  logic [UART_DATA_BITS-1:0] load_byte_s;
  logic                      clr_s;
  logic [CNT_W-1:0]          cnt_s;
  logic                      tick_s;

  assign start_s     = bus.tx_send_en & bus.tx_send;
  // A byte written in the same clk as the start strobe is the one sent.
  assign load_byte_s = bus.tx_data_en ? bus.Tx_Data_w : hold_r;
  // Idle keeps the counter parked at zero; any state change restarts it.
  assign clr_s       = (state_nxt_s != state_r) | (state_r == TX_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .cnt  (cnt_s),
    .tick (tick_s)
  );

  // Holding register written by the controller in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r <= 8'h00;
    end else if (bus.tx_data_en) begin
      hold_r <= bus.Tx_Data_w;
    end
  end

  // Next-state, shift, bit-index and parity decode.
  always_comb begin
    state_nxt_s = state_r;
    shift_nxt_s = shift_r;
    idx_nxt_s   = idx_r;
    par_nxt_s   = par_r;
    unique case (state_r)
      TX_IDLE: begin
        if (start_s) begin
          state_nxt_s = TX_START;
          shift_nxt_s = load_byte_s;
          idx_nxt_s   = 3'd0;
          par_nxt_s   = parity_bit(load_byte_s, PAR_ODD);
        end else begin
          state_nxt_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (tick_s) begin
          state_nxt_s = TX_DATA;
        end else begin
          state_nxt_s = TX_START;
        end
      end
      TX_DATA: begin
        if (tick_s) begin
          shift_nxt_s = {1'b0, shift_r[UART_DATA_BITS-1:1]};
          idx_nxt_s   = idx_r + 3'd1;
          if (idx_r == 3'd7) begin
            state_nxt_s = PAR_EN ? TX_PARITY : TX_STOP;
          end else begin
            state_nxt_s = TX_DATA;
          end
        end else begin
          state_nxt_s = TX_DATA;
        end
      end
      TX_PARITY: begin
        if (tick_s) begin
          state_nxt_s = TX_STOP;
        end else begin
          state_nxt_s = TX_PARITY;
        end
      end
      TX_STOP: begin
        if (tick_s) begin
          state_nxt_s = TX_IDLE;
        end else begin
          state_nxt_s = TX_STOP;
        end
      end
      default: begin
        state_nxt_s = TX_IDLE;
      end
    endcase
  end

  // Registered line level and done pulse, decoded from the upcoming state.
  always_comb begin
    tx_nxt_s   = 1'b1;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      TX_IDLE:   tx_nxt_s = 1'b1;
      TX_START:  tx_nxt_s = 1'b0;
      TX_DATA:   tx_nxt_s = shift_nxt_s[0];
      TX_PARITY: tx_nxt_s = par_nxt_s;
      TX_STOP:   tx_nxt_s = 1'b1;
      default:   tx_nxt_s = 1'b1;
    endcase
    if (state_nxt_s == TX_STOP) begin
      // The next clk is the last one of STOP.
      if (state_r == TX_STOP) begin
        done_nxt_s = (cnt_s == PRE_LAST);
      end else begin
        done_nxt_s = STOP_ONE_CLK;
      end
    end else begin
      done_nxt_s = 1'b0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= TX_IDLE;
      shift_r <= 8'h00;
      idx_r   <= 3'd0;
      par_r   <= 1'b0;
      tx_r    <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      shift_r <= shift_nxt_s;
      idx_r   <= idx_nxt_s;
      par_r   <= par_nxt_s;
      tx_r    <= tx_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign bus.tx               = tx_r;
  assign bus.tx_done          = done_r;
  assign bus.tx_busy          = (state_r != TX_IDLE);
  assign bus.tx_fsm_in_STOP_S = (state_r == TX_STOP);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: three instances (even parity, odd
// parity, no parity) with a per-clk line scoreboard.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic exp_q0[$];
  logic exp_q1[$];
  logic exp_q2[$];

  always #5 clk = ~clk;

  uart_tx_ctrl_if if0();
  uart_tx_ctrl_if if1();
  uart_tx_ctrl_if if2();

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // Scoreboard: each queued level is compared with the line mid-cycle.
  always @(negedge clk) begin
    logic e;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front(); n_cmp++;
      if (if0.tx !== e) begin n_fail++; $display("FAIL sb_tx0 t=%0t got=%b exp=%b", $time, if0.tx, e); end
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front(); n_cmp++;
      if (if1.tx !== e) begin n_fail++; $display("FAIL sb_tx1 t=%0t got=%b exp=%b", $time, if1.tx, e); end
    end
    if (exp_q2.size() > 0) begin
      e = exp_q2.pop_front(); n_cmp++;
      if (if2.tx !== e) begin n_fail++; $display("FAIL sb_tx2 t=%0t got=%b exp=%b", $time, if2.tx, e); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line levels of one frame, CPB clks per bit, truncated to limit.
  task automatic push_frame(input int which, input logic [7:0] b, input int limit);
    logic bits[$];
    logic en;
    logic odd;
    int   n;
    en  = (which == 2) ? 1'b0 : 1'b1;
    odd = (which == 1) ? 1'b1 : 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (en) bits.push_back((^b) ^ odd);
    bits.push_back(1'b1);
    n = 0;
    foreach (bits[j]) begin
      for (int c = 0; c < CPB; c++) begin
        if (n < limit) begin
          if (which == 0) exp_q0.push_back(bits[j]);
          else if (which == 1) exp_q1.push_back(bits[j]);
          else exp_q2.push_back(bits[j]);
        end
        n++;
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) rst = 1'b0;
      tick();
      n_cmp++;
      if ({if0.tx, if0.tx_busy, if0.tx_done, if0.tx_fsm_in_STOP_S} !== 4'b1000) begin
        n_fail++; $display("FAIL reset_state k=%0d got=%b exp=1000", k, {if0.tx, if0.tx_busy, if0.tx_done, if0.tx_fsm_in_STOP_S});
      end
      n_cmp++;
      if ({if1.tx, if1.tx_busy, if2.tx, if2.tx_busy} !== 4'b1010) begin
        n_fail++; $display("FAIL reset_others k=%0d got=%b exp=1010", k, {if1.tx, if1.tx_busy, if2.tx, if2.tx_busy});
      end
    end
  endtask

  task automatic test_even_55();
    if0.tx_data_en = 1'b1; if0.Tx_Data_w = 8'h55;
    tick();
    if0.tx_data_en = 1'b0;
    n_cmp++;
    if (if0.tx_busy !== 1'b0) begin n_fail++; $display("FAIL load_no_start got=%b exp=0", if0.tx_busy); end
    if0.tx_send_en = 1'b1; if0.tx_send = 1'b1;
    tick();
    if0.tx_send_en = 1'b0; if0.tx_send = 1'b0;
    push_frame(0, 8'h55, 1000);
    for (int k = 1; k <= 44; k++) begin
      n_cmp++;
      if (if0.tx_busy !== 1'b1) begin n_fail++; $display("FAIL busy_55 clk=%0d got=%b exp=1", k, if0.tx_busy); end
      n_cmp++;
      if (if0.tx_fsm_in_STOP_S !== (k >= 41)) begin n_fail++; $display("FAIL stop_flag_55 clk=%0d got=%b exp=%b", k, if0.tx_fsm_in_STOP_S, (k >= 41)); end
      n_cmp++;
      if (if0.tx_done !== (k == 44)) begin n_fail++; $display("FAIL done_55 clk=%0d got=%b exp=%b", k, if0.tx_done, (k == 44)); end
      tick();
    end
    n_cmp++;
    if ({if0.tx, if0.tx_busy, if0.tx_done} !== 3'b100) begin
      n_fail++; $display("FAIL idle_after_55 got=%b exp=100", {if0.tx, if0.tx_busy, if0.tx_done});
    end
  endtask

  task automatic test_parity_variants();
    if1.tx_data_en = 1'b1; if1.Tx_Data_w = 8'hA7;
    if2.tx_data_en = 1'b1; if2.Tx_Data_w = 8'hA7;
    tick();
    if1.tx_data_en = 1'b0; if2.tx_data_en = 1'b0;
    if1.tx_send_en = 1'b1; if1.tx_send = 1'b1;
    if2.tx_send_en = 1'b1; if2.tx_send = 1'b1;
    tick();
    if1.tx_send_en = 1'b0; if1.tx_send = 1'b0;
    if2.tx_send_en = 1'b0; if2.tx_send = 1'b0;
    push_frame(1, 8'hA7, 1000);
    push_frame(2, 8'hA7, 1000);
    for (int k = 1; k <= 44; k++) begin
      if (k == 38) begin
        n_cmp++;
        if (if1.tx !== 1'b0) begin n_fail++; $display("FAIL odd_parity_a7 got=%b exp=0", if1.tx); end
      end
      n_cmp++;
      if (if1.tx_done !== (k == 44)) begin n_fail++; $display("FAIL done_odd clk=%0d got=%b exp=%b", k, if1.tx_done, (k == 44)); end
      n_cmp++;
      if (if2.tx_done !== (k == 40)) begin n_fail++; $display("FAIL done_nopar clk=%0d got=%b exp=%b", k, if2.tx_done, (k == 40)); end
      n_cmp++;
      if (if2.tx_busy !== (k <= 40)) begin n_fail++; $display("FAIL busy_nopar clk=%0d got=%b exp=%b", k, if2.tx_busy, (k <= 40)); end
      tick();
    end
    n_cmp++;
    if (if1.tx_busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_odd got=%b exp=0", if1.tx_busy); end
  endtask

  task automatic test_ignored_strobes();
    if0.tx_data_en = 1'b1; if0.Tx_Data_w = 8'h12;
    tick();
    if0.tx_data_en = 1'b0;
    if0.tx_send_en = 1'b1; if0.tx_send = 1'b1;
    tick();
    if0.tx_send_en = 1'b0; if0.tx_send = 1'b0;
    push_frame(0, 8'h12, 1000);
    for (int k = 1; k <= 44; k++) begin
      if (k == 10) begin if0.tx_send_en = 1'b1; if0.tx_send = 1'b1; end
      if (k == 11) begin if0.tx_send_en = 1'b0; if0.tx_send = 1'b0; end
      if (k == 20) begin if0.tx_data_en = 1'b1; if0.Tx_Data_w = 8'hFF; end
      if (k == 21) if0.tx_data_en = 1'b0;
      n_cmp++;
      if (if0.tx_done !== (k == 44)) begin n_fail++; $display("FAIL done_ign clk=%0d got=%b exp=%b", k, if0.tx_done, (k == 44)); end
      tick();
    end
    n_cmp++;
    if (if0.tx_busy !== 1'b0) begin n_fail++; $display("FAIL no_queued_start got=%b exp=0", if0.tx_busy); end
    if0.tx_send_en = 1'b1; if0.tx_send = 1'b0;
    tick();
    if0.tx_send_en = 1'b0;
    n_cmp++;
    if ({if0.tx, if0.tx_busy} !== 2'b10) begin n_fail++; $display("FAIL send_zero got=%b exp=10", {if0.tx, if0.tx_busy}); end
    if0.tx_send_en = 1'b1; if0.tx_send = 1'b1;
    tick();
    if0.tx_send_en = 1'b0; if0.tx_send = 1'b0;
    push_frame(0, 8'hFF, 1000);
    for (int k = 1; k <= 44; k++) begin
      n_cmp++;
      if (if0.tx_done !== (k == 44)) begin n_fail++; $display("FAIL done_ff clk=%0d got=%b exp=%b", k, if0.tx_done, (k == 44)); end
      tick();
    end
  endtask

  task automatic test_simultaneous_load();
    if0.tx_data_en = 1'b1; if0.Tx_Data_w = 8'h3C;
    if0.tx_send_en = 1'b1; if0.tx_send = 1'b1;
    tick();
    if0.tx_data_en = 1'b0; if0.tx_send_en = 1'b0; if0.tx_send = 1'b0;
    push_frame(0, 8'h3C, 1000);
    for (int k = 1; k <= 44; k++) tick();
    n_cmp++;
    if (if0.tx_busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_3c got=%b exp=0", if0.tx_busy); end
  endtask

  task automatic test_back_to_back();
    if0.tx_data_en = 1'b1; if0.Tx_Data_w = 8'h5A;
    if0.tx_send_en = 1'b1; if0.tx_send = 1'b1;
    tick();
    if0.tx_data_en = 1'b0; if0.tx_send_en = 1'b0; if0.tx_send = 1'b0;
    push_frame(0, 8'h5A, 1000);
    for (int k = 1; k <= 44; k++) tick();
    n_cmp++;
    if ({if0.tx, if0.tx_busy} !== 2'b10) begin n_fail++; $display("FAIL b2b_idle_clk got=%b exp=10", {if0.tx, if0.tx_busy}); end
    if0.tx_data_en = 1'b1; if0.Tx_Data_w = 8'hC3;
    if0.tx_send_en = 1'b1; if0.tx_send = 1'b1;
    tick();
    if0.tx_data_en = 1'b0; if0.tx_send_en = 1'b0; if0.tx_send = 1'b0;
    push_frame(0, 8'hC3, 1000);
    n_cmp++;
    if ({if0.tx, if0.tx_busy} !== 2'b01) begin n_fail++; $display("FAIL b2b_start got=%b exp=01", {if0.tx, if0.tx_busy}); end
    for (int k = 1; k <= 44; k++) begin
      n_cmp++;
      if (if0.tx_done !== (k == 44)) begin n_fail++; $display("FAIL done_b2b clk=%0d got=%b exp=%b", k, if0.tx_done, (k == 44)); end
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    if0.tx_data_en = 1'b1; if0.Tx_Data_w = 8'h99;
    if0.tx_send_en = 1'b1; if0.tx_send = 1'b1;
    tick();
    if0.tx_data_en = 1'b0; if0.tx_send_en = 1'b0; if0.tx_send = 1'b0;
    push_frame(0, 8'h99, 10);
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    n_cmp++;
    if ({if0.tx, if0.tx_busy, if0.tx_done, if0.tx_fsm_in_STOP_S} !== 4'b1000) begin
      n_fail++; $display("FAIL mid_reset got=%b exp=1000", {if0.tx, if0.tx_busy, if0.tx_done, if0.tx_fsm_in_STOP_S});
    end
    for (int k = 0; k < 40; k++) begin
      n_cmp++;
      if ({if0.tx, if0.tx_busy, if0.tx_done} !== 3'b100) begin
        n_fail++; $display("FAIL abandoned_frame k=%0d got=%b exp=100", k, {if0.tx, if0.tx_busy, if0.tx_done});
      end
      tick();
    end
    if0.tx_data_en = 1'b1; if0.Tx_Data_w = 8'h81;
    tick();
    if0.tx_data_en = 1'b0;
    if0.tx_send_en = 1'b1; if0.tx_send = 1'b1;
    tick();
    if0.tx_send_en = 1'b0; if0.tx_send = 1'b0;
    push_frame(0, 8'h81, 1000);
    for (int k = 1; k <= 44; k++) begin
      n_cmp++;
      if (if0.tx_done !== (k == 44)) begin n_fail++; $display("FAIL done_81 clk=%0d got=%b exp=%b", k, if0.tx_done, (k == 44)); end
      tick();
    end
  endtask

  initial begin
    if0.tx_data_en = 1'b0; if0.Tx_Data_w = 8'h00; if0.tx_send_en = 1'b0; if0.tx_send = 1'b0;
    if1.tx_data_en = 1'b0; if1.Tx_Data_w = 8'h00; if1.tx_send_en = 1'b0; if1.tx_send = 1'b0;
    if2.tx_data_en = 1'b0; if2.Tx_Data_w = 8'h00; if2.tx_send_en = 1'b0; if2.tx_send = 1'b0;
    test_reset();
    test_even_55();
    test_parity_variants();
    test_ignored_strobes();
    test_simultaneous_load();
    test_back_to_back();
    test_reset_mid_frame();
    tick();
    n_cmp++;
    if ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0) begin
      n_fail++; $display("FAIL sb_drained got=%0d exp=0", exp_q0.size() + exp_q1.size() + exp_q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
